pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, memory-wait freeze
// Control outputs are combinational from state and inputs; state, counters and err_o are registered.
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             mem_br_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             pipe_freeze_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TO_FULL = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_FLUSH    = 2'd2,
        S_MEM_WAIT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_err;
    logic              w_mem_wait;
    logic              w_branch;
    logic              w_src_hit;
    logic              w_lu_ok;
    logic              w_load_use;

    assign w_mem_wait = dmem_req_i & ~dmem_ready_i;
    assign w_branch   = mem_br_taken_i & ~w_mem_wait;
    assign w_src_hit  = (ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i));
    // The release cycle of a memory wait evaluates hazards exactly like RUN.
    assign w_lu_ok    = (r_state == S_RUN) | (r_state == S_MEM_WAIT);
    assign w_load_use = w_lu_ok & ex_memread_i & (ex_rt_i != 5'd0) & w_src_hit
                        & ~w_mem_wait & ~w_branch;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        pipe_freeze_o = 1'b0;
        w_next        = S_RUN;
        if (rst_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (w_mem_wait) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            pipe_freeze_o = 1'b1;
            w_next        = S_MEM_WAIT;
        end else if (w_branch) begin
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            w_next        = S_FLUSH;
        end else if (w_load_use) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
            w_next       = S_LU_STALL;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (!pc_write_o && r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_branch && r_flush_cnt != CNT_MAX) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            // err_o latches on the MEM_TIMEOUT-th consecutive wait cycle and stays until reset.
            if (w_mem_wait) begin
                if (r_wait_cnt != TO_FULL) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                if (r_wait_cnt >= TO_LAST) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign state_o     = r_state;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
    assign err_o       = r_err;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 15;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_memread, mem_br_taken, dmem_req, dmem_ready;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;
    int m_state, m_stall, m_flush, m_wait;
    int m_err;
    int wait_run = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .mem_br_taken_i(mem_br_taken),
        .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write),
        .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush), .exmem_flush_o(exmem_flush),
        .pipe_freeze_o(pipe_freeze), .state_o(state),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .err_o(err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Event this cycle: 3 memory wait, 2 branch, 1 load-use, 0 none; it doubles as the next state.
    function automatic int ev_now();
        if (dmem_req && !dmem_ready) return 3;
        if (mem_br_taken) return 2;
        if ((m_state == 0 || m_state == 3) && ex_memread && ex_rt != 0 &&
            (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt))) return 1;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0; m_stall <= 0; m_flush <= 0; m_wait <= 0; m_err <= 0;
        end else begin
            m_state <= ev_now();
            if (ev_now() == 3 || ev_now() == 1) m_stall <= (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (ev_now() == 2) m_flush <= (m_flush < CMAX) ? m_flush + 1 : CMAX;
            if (ev_now() == 3) begin
                m_wait <= m_wait + 1;
                if (m_wait + 1 >= MEM_TIMEOUT) m_err <= 1;
            end else begin
                m_wait <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("m_pc", pc_write, 0);       chk("m_ifid_w", ifid_write, 0);
            chk("m_ifid_f", ifid_flush, 0); chk("m_idex_f", idex_flush, 0);
            chk("m_exmem_f", exmem_flush, 0); chk("m_freeze", pipe_freeze, 0);
        end else begin
            chk("m_pc", pc_write, int'(!(ev_now() == 3 || ev_now() == 1)));
            chk("m_ifid_w", ifid_write, int'(!(ev_now() == 3 || ev_now() == 1)));
            chk("m_ifid_f", ifid_flush, int'(ev_now() == 2));
            chk("m_idex_f", idex_flush, int'(ev_now() == 2 || ev_now() == 1));
            chk("m_exmem_f", exmem_flush, int'(ev_now() == 2));
            chk("m_freeze", pipe_freeze, int'(ev_now() == 3));
        end
        chk("m_state", state, m_state);
        chk("m_stall", stall_cnt, m_stall);
        chk("m_flush", flush_cnt, m_flush);
        chk("m_err", err, m_err);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; ex_memread = 0;
        mem_br_taken = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #2 rst = 1'b1;
        #1;
        chk("rst_state", state, 0);  chk("rst_pc", pc_write, 0);
        chk("rst_stall", stall_cnt, 0); chk("rst_err", err, 0);
        tick(); tick();
        rst = 1'b0;
        #1 chk("idle_pc", pc_write, 1);
        tick();

        // Load-use on rs
        ex_memread = 1; ex_rt = 8; id_rs = 8;
        #1 chk("lu_pc", pc_write, 0); chk("lu_idex", idex_flush, 1); chk("lu_ifid_w", ifid_write, 0);
        tick();
        chk("lu_state", state, 1); chk("lu_stall", stall_cnt, 1); chk("lu_suppressed_pc", pc_write, 1);
        idle();
        tick();
        chk("lu_back_run", state, 0);

        // $0 and unused rt never hazard
        ex_memread = 1; ex_rt = 0; id_rs = 0;
        #1 chk("r0_pc", pc_write, 1);
        ex_rt = 9; id_rt = 9; id_rs = 1; id_uses_rt = 0;
        #1 chk("rt_unused_pc", pc_write, 1);
        id_uses_rt = 1;
        #1 chk("rt_used_pc", pc_write, 0);
        idle();
        tick();

        // Branch coincident with load-use
        do_reset();
        ex_memread = 1; ex_rt = 8; id_rs = 8; mem_br_taken = 1;
        #1 chk("br_ifid_f", ifid_flush, 1); chk("br_idex_f", idex_flush, 1);
        chk("br_exmem_f", exmem_flush, 1); chk("br_pc", pc_write, 1);
        tick();
        chk("br_flush_cnt", flush_cnt, 1); chk("br_stall_cnt", stall_cnt, 0); chk("br_state", state, 2);
        idle();
        tick();

        // Short memory wait, then timeout
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mw_freeze", pipe_freeze, 1);
            tick();
        end
        chk("mw_stall3", stall_cnt, 3); chk("mw_state", state, 3);
        dmem_ready = 1;
        #1 chk("mw_rel_freeze", pipe_freeze, 0); chk("mw_rel_pc", pc_write, 1);
        tick();
        chk("mw_run", state, 0); chk("mw_no_err", err, 0);
        dmem_ready = 0;
        for (int i = 0; i < 14; i++) tick();
        chk("to_14_err", err, 0);
        tick();
        chk("to_15_err", err, 1); chk("to_freeze", pipe_freeze, 1);
        dmem_ready = 1;
        tick(); tick();
        chk("to_err_sticky", err, 1);
        idle();

        // Stall counter saturation, then async reset mid-wait
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 16; i++) tick();
        chk("sat_stall", stall_cnt, 15);
        tick();
        chk("sat_stall_hold", stall_cnt, 15); chk("sat_state", state, 3);
        #2 rst = 1'b1;
        #1 chk("arst_state", state, 0); chk("arst_err", err, 0);
        chk("arst_stall", stall_cnt, 0); chk("arst_freeze", pipe_freeze, 0);
        tick();
        rst = 1'b0; idle();
        #1 chk("arst_rel_state", state, 0); chk("arst_rel_pc", pc_write, 1);
        tick();

        // Reset mid-LU_STALL
        ex_memread = 1; ex_rt = 5; id_rt = 5; id_uses_rt = 1;
        tick();
        chk("lus_state", state, 1);
        #2 rst = 1'b1;
        #1 chk("lus_rst_state", state, 0);
        tick();
        rst = 1'b0; idle();
        #1 chk("lus_rel_pc", pc_write, 1);
        tick();

        // Flush counter saturation
        do_reset();
        mem_br_taken = 1;
        for (int i = 0; i < 17; i++) tick();
        chk("sat_flush", flush_cnt, 15);
        idle();
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 149) == 0);
            ex_memread   = ($urandom_range(0, 1) == 1);
            ex_rt        = 5'($urandom_range(0, 3));
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = ($urandom_range(0, 1) == 1);
            mem_br_taken = ($urandom_range(0, 5) == 0);
            if (wait_run == 0 && $urandom_range(0, 199) == 0) wait_run = int'($urandom_range(14, 20));
            if (wait_run > 0) begin
                dmem_req = 1; dmem_ready = 0; wait_run--;
            end else begin
                dmem_req   = ($urandom_range(0, 3) == 0);
                dmem_ready = ($urandom_range(0, 1) == 1);
            end
            tick();
        end
        rst = 1'b0; idle();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
